jt12_wrq: RTL
=============

Name: jt12_wrq

Overview:
- Parametrised CPU write front-end for the JT12 register map. It replaces the single-shot write/busy latch with a per-part address latch plus a write FIFO.
- CPU address/data writes become {part, register, data} records. These are queued and drained by the register-file side through a valid/ready handshake.
- The CPU-visible busy flag emulates the chip's per-write busy time, independently of the queue.
- Sits between the bus interface and the register decoder/jt12_reg update logic.

Parameters:
- PART_W, 1, width of the part-select field. Number of parts = 2^PART_W; the YM2612 uses 2.
- DEPTH, 8, FIFO depth in records. Power of two, minimum 2.
- BUSY_CYCLES, 32, clk cycles busy stays high after an accepted data write. Minimum 1.
- LVL_W, 4, width of the level output. Must be at least clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- write  in  1  one-cycle CPU write strobe.
- addr  in  PART_W+1  addr[0]: 0 = address write, 1 = data write. addr[PART_W:1] = part.
- din  in  8  CPU write data.
- busy  out  1  CPU status busy flag.
- full  out  1  FIFO holds DEPTH records.
- ovf  out  1  sticky overflow flag.
- clr_ovf  in  1  clears ovf.
- level  out  LVL_W  number of records currently queued.
- out_valid  out  1  head record present.
- out_ready  in  1  consumer accepts the head record.
- out_part  out  PART_W  head record part.
- out_reg  out  8  head record register number.
- out_data  out  8  head record data.

Behaviour:
- Reset values:
  - busy=0, full=0, ovf=0, level=0, out_valid=0.
  - out_part, out_reg and out_data = 0.
  - All per-part selected-register latches = 0x00.
  - Busy counter = 0.
  - FIFO read and write pointers = 0.
- Reset mid-operation discards all queued records and any running busy count.
- Address write (write=1, addr[0]=0):
  - sel[part] <= din.
  - Never enqueues, never affects busy.
  - Always accepted, including while busy or full.
- Data write (write=1, addr[0]=1):
  - Record {part, sel[part], din} is pushed when the FIFO is not full at that clock edge.
  - sel[part] is the value latched before this cycle.
  - A data write while busy=1 is still accepted if there is space; CPU-side busy polling is advisory only.
- Full FIFO and data writes:
  - A data write while full is dropped: the FIFO is unchanged and ovf <= 1.
  - This holds even if a pop happens in the same cycle. Full is evaluated before the pop.
- Pop: occurs when out_valid && out_ready. The head advances.
- Queue view:
  - out_* always presents the oldest record while out_valid=1.
  - out_* is stable and held while out_valid && !out_ready.
  - Push to an empty FIFO makes out_valid=1 on the next cycle (1-cycle latency).
- Simultaneous push and pop with a non-empty, non-full FIFO: level is unchanged and order is preserved.
- Pointers wrap modulo DEPTH. level is exact, 0..DEPTH. full = (level==DEPTH).
- Busy counter:
  - An accepted data write loads the counter with BUSY_CYCLES.
  - Otherwise the counter decrements while nonzero.
  - busy = (counter != 0) || full.
  - busy rises in the cycle after the accepted write and stays high exactly BUSY_CYCLES cycles if the queue is not full.
  - A new accepted write reloads the counter; it does not accumulate.
- ovf:
  - Set on any dropped write.
  - Cleared by clr_ovf.
  - A drop in the same cycle as clr_ovf wins: ovf stays 1.
- No other outputs change on address writes. Writes to nonexistent registers are still queued; decode belongs downstream.

Test Plan:
- Reset, then addr write part0=0x28, data write 0xF1 with out_ready=0 -> next cycle: out_valid=1, out_part=0, out_reg=0x28, out_data=0xF1, level=1; busy high for exactly 32 cycles.
- Addr writes part0=0xA4 and part1=0x30, then data 0x22 to part1 and 0x11 to part0 -> records pop in order {1,0x30,0x22} then {0,0xA4,0x11}; sel latches unchanged after the data writes.
- With out_ready=0, issue 9 data writes -> level reaches 8, full=1, busy=1, ovf=1 after the 9th; the 9th record is absent on drain. Then clr_ovf -> ovf=0.
- With the FIFO full, a data write coinciding with out_ready=1 -> the write is dropped, ovf=1, level=7.
- Steady stream of data writes every cycle with out_ready=1 -> level stays 1 and pointers wrap past DEPTH without loss or reorder; verify 20 sequential data values.
- Fill 5 records, assert rst for one cycle mid-drain -> out_valid=0, level=0, busy=0, ovf=0, sel=0x00 next cycle; a subsequent data write to part0 queues reg 0x00.

Source files
------------

// File: rtl/jt12_wrq.sv
// JT12 CPU write front-end: per-part register-address latches feeding a record FIFO,
// plus an emulated per-write busy flag for the CPU status read.
module jt12_wrq #(
  parameter int unsigned PART_W      = 1,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BUSY_CYCLES = 32,
  parameter int unsigned LVL_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [PART_W:0]   addr,
  input  logic [7:0]        din,
  output logic              busy,
  output logic              full,
  output logic              ovf,
  input  logic              clr_ovf,
  output logic [LVL_W-1:0]  level,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PART_W-1:0] out_part,
  output logic [7:0]        out_reg,
  output logic [7:0]        out_data
);

  localparam int unsigned NPARTS = 1 << PART_W;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(BUSY_CYCLES + 1);
  localparam int unsigned REC_W  = PART_W + 16;

  logic [7:0]       sel [NPARTS];
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [REC_W-1:0] rec_in, head_nxt;
  logic [PART_W-1:0] part;
  logic             is_data, push, drop, pop;

  // Push/pop decisions use registered full, so a pop never frees room for a same-cycle write
  always_comb begin
    part      = addr[PART_W:1];
    is_data   = write & addr[0];
    push      = is_data & ~full;
    drop      = is_data & full;
    pop       = out_valid & out_ready;
    rec_in    = {part, sel[part], din};
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LVL_W'(1);
    else if (!push && pop)
      level_nxt = level - LVL_W'(1);
    rd_nxt   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    // A push into an empty (or just-emptied) queue becomes the head directly
    head_nxt = (push && (wr_ptr == rd_nxt)) ? rec_in : mem[rd_nxt];
    cnt_nxt  = cnt;
    if (push)
      cnt_nxt = CNT_W'(BUSY_CYCLES);
    else if (cnt != '0)
      cnt_nxt = cnt - CNT_W'(1);
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rec_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPARTS; i++)
        sel[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      level     <= '0;
      busy      <= 1'b0;
      full      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_part  <= '0;
      out_reg   <= '0;
      out_data  <= '0;
    end else begin
      if (write && !addr[0])
        sel[part] <= din;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_nxt;
      cnt       <= cnt_nxt;
      level     <= level_nxt;
      full      <= (level_nxt == LVL_W'(DEPTH));
      busy      <= (cnt_nxt != '0) || (level_nxt == LVL_W'(DEPTH));
      out_valid <= (level_nxt != '0);
      if (level_nxt != '0)
        {out_part, out_reg, out_data} <= head_nxt;
      // A drop in the same cycle as a clear leaves the flag set
      if (drop)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule
